booth_mult_seq: RTL and testbench

//   Sequential radix-2 Booth multiplier, parametrised in operand width, with a signed/unsigned mode.
//   One Booth iteration per clock. valid/ready handshakes on input and output.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/booth_step.sv | 35 +++
 rtl/booth_mult_seq.sv | 129 ++++++++++++
 tb/tb_booth_mult_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// +----------------------------------------------------------------------------+
// | mult_pkg : shared state encoding, mode codes and operand extension helper. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Extends the low `width` bits of val to 64 bits, sign- or zero-filled by mode.
  function automatic logic [63:0] booth_ext(input int width, input logic [63:0] val,
                                            input logic sgn);
    logic [63:0] mask;
    logic        sign_bit;
    mask     = ~64'd0 << width;
    sign_bit = (sgn == MODE_SIGNED) && (((val >> (width - 1)) & 64'd1) != 64'd0);
    return sign_bit ? (val | mask) : (val & ~mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// +----------------------------------------------------------------------------+
// | booth_step : one radix-2 Booth iteration (add/sub then arithmetic shift).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] a_in,
  input  logic [WIDTH:0]   q_in,
  input  logic             q1_in,
  input  logic [WIDTH+1:0] m_in,
  output logic [WIDTH+1:0] a_out,
  output logic [WIDTH:0]   q_out,
  output logic             q1_out
);

  logic [WIDTH+1:0] sum;

  always_comb begin
    sum = a_in;
    case ({q_in[0], q1_in})
      2'b10:   sum = a_in - m_in;
      2'b01:   sum = a_in + m_in;
      default: sum = a_in;
    endcase
    a_out  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    q_out  = {sum[0], q_in[WIDTH:1]};
    q1_out = q_in[0];
  end

endmodule

`default_nettype wire

// File: rtl/booth_mult_seq.sv
// +----------------------------------------------------------------------------+
// | booth_mult_seq : sequential radix-2 Booth multiplier, valid/ready on both  |
// | sides, one iteration per clock. Rev 1.0                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int AW    = WIDTH + 2;
  localparam int QW    = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);

  logic [1:0]           state_q,   state_d;
  logic [AW-1:0]        m_q,       m_d;
  logic [AW-1:0]        a_q,       a_d;
  logic [QW-1:0]        q_q,       q_d;
  logic                 q1_q,      q1_d;
  logic [CNT_W-1:0]     count_q,   count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [AW-1:0]        m_ext;
  logic [QW-1:0]        q_ext;
  logic [AW-1:0]        step_a;
  logic [QW-1:0]        step_q;
  logic                 step_q1;
  logic                 last_iter;

  assign m_ext     = AW'(booth_ext(WIDTH, 64'(a), is_signed));
  assign q_ext     = QW'(booth_ext(WIDTH, 64'(b), is_signed));
  assign last_iter = (count_q == LAST_ITER);

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_in   (a_q),
    .q_in   (q_q),
    .q1_in  (q1_q),
    .m_in   (m_q),
    .a_out  (step_a),
    .q_out  (step_q),
    .q1_out (step_q1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_BUSY;
      ST_BUSY: if (last_iter) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m_d     = m_ext;
          q_d     = q_ext;
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = '0;
        end
      end
      ST_BUSY: begin
        a_d     = step_a;
        q_d     = step_q;
        q1_d    = step_q1;
        count_d = count_q + 1'b1;
        // Low 2*WIDTH bits of {A,Q} after the final shift.
        if (last_iter) product_d = {step_a[WIDTH-2:0], step_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
    product   = product_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
// +----------------------------------------------------------------------------+
// | tb_booth_mult_seq : directed WIDTH=4 table and random WIDTH=8 checks.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_booth_mult_seq;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid4, in_ready4, sgn4, out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] product4;

  logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic       sgn;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .is_signed(sgn4), .out_valid(out_valid4),
    .out_ready(out_ready4), .product(product4), .busy(busy4)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .is_signed(sgn8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul8(input logic sg, input logic [7:0] x, input logic [7:0] y);
    int xi, yi, p;
    xi = sg ? int'($signed(x)) : int'(x);
    yi = sg ? int'($signed(y)) : int'(y);
    p  = xi * yi;
    return p[15:0];
  endfunction

  task automatic start4(input logic sg, input logic [3:0] x, input logic [3:0] y);
    sgn4 = sg; a4 = x; b4 = y; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); sgn4 = ~sg;
    chk("accept_busy", {in_ready4, busy4}, 2'b01);
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain4();
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("drain_in_ready", in_ready4, 1'b1);
    chk("drain_out_valid", out_valid4, 1'b0);
  endtask

  initial begin
    int          lat;
    logic [7:0]  p_hold;
    logic        seen;
    logic        sg;
    logic [7:0]  ra, rb;

    vecs[0] = '{1'b1, 4'hD, 4'h5, 8'hF1};
    vecs[1] = '{1'b0, 4'hF, 4'hF, 8'hE1};
    vecs[2] = '{1'b1, 4'hF, 4'hF, 8'h01};
    vecs[3] = '{1'b1, 4'h8, 4'h8, 8'h40};
    vecs[4] = '{1'b1, 4'h8, 4'h7, 8'hC8};
    vecs[5] = '{1'b0, 4'h8, 4'h8, 8'h40};
    vecs[6] = '{1'b0, 4'h0, 4'hF, 8'h00};
    vecs[7] = '{1'b1, 4'h7, 4'h7, 8'h31};
    vecs[8] = '{1'b0, 4'hF, 4'h1, 8'h0F};

    rst = 1'b1;
    in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; sgn4 = 0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; sgn8 = 0;
    tick();
    tick();
    chk("reset_out_valid", out_valid4, 1'b0);
    chk("reset_busy", busy4, 1'b0);
    chk("reset_product", product4, 8'h00);
    chk("reset_in_ready", in_ready4, 1'b1);
    chk("reset_w8", {in_ready8, out_valid8, busy8, product8}, {1'b1, 18'h0});
    rst = 1'b0;
    tick();

    // Directed WIDTH=4 table; latency from accept edge to out_valid is WIDTH+1.
    for (int i = 0; i < 9; i++) begin
      start4(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait4(lat);
      chk($sformatf("latency_v%0d", i), lat, 5);
      chk($sformatf("product_v%0d", i), product4, vecs[i].exp);
      drain4();
    end

    // Backpressure: result and handshake state hold while out_ready is low.
    start4(1'b1, 4'hD, 4'h5);
    wait4(lat);
    p_hold = product4;
    chk("bp_product", p_hold, 8'hF1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {out_valid4, in_ready4, busy4, product4}, {3'b101, 8'hF1});
    end
    drain4();

    // Reset two cycles into BUSY aborts the op at once.
    start4(1'b0, 4'hF, 4'hF);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid4, 1'b0);
    chk("rst_mid_product", product4, 8'h00);
    chk("rst_mid_in_ready", in_ready4, 1'b1);
    chk("rst_mid_busy", busy4, 1'b0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid4 || busy4) seen = 1'b1;
    end
    chk("rst_no_stale", seen, 1'b0);

    // WIDTH=8 random operands, with in_valid held high and junk operands while busy.
    for (int i = 0; i < 1500; i++) begin
      sg = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      case (i)
        0: begin sg = 1; ra = 8'h80; rb = 8'h80; end
        1: begin sg = 1; ra = 8'h80; rb = 8'h7F; end
        2: begin sg = 0; ra = 8'hFF; rb = 8'hFF; end
        3: begin sg = 1; ra = 8'hFF; rb = 8'hFF; end
        4: begin sg = 0; ra = 8'h80; rb = 8'h80; end
        5: begin sg = 1; ra = 8'h7F; rb = 8'h7F; end
        6: begin sg = 0; ra = 8'h00; rb = 8'hFF; end
        7: begin sg = 1; ra = 8'hFF; rb = 8'h80; end
        default: ;
      endcase
      sgn8 = sg; a8 = ra; b8 = rb; in_valid8 = 1'b1;
      tick();
      lat = 0;
      while (!out_valid8 && lat < 30) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
        tick();
        lat++;
      end
      chk($sformatf("w8_latency_%0d", i), lat, 9);
      chk($sformatf("w8_product_%0d_s%0d_%0h_%0h", i, sg, ra, rb), product8, ref_mul8(sg, ra, rb));
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      chk($sformatf("w8_idle_%0d", i), {in_ready8, busy8, out_valid8}, 3'b100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
